// File: rtl/adaptive_filter_mode_ctrl.sv
// Mode-switch sequencer for adaptive_filter: back-pressures, drains, flushes and
// re-applies ctrl, then blanks filter output until the new mode's state has refilled.
module adaptive_filter_mode_ctrl #(
  parameter int   DATA_WL        = 14,
  parameter int   DRAIN_CYCLES   = 1,
  parameter int   FLUSH_CYCLES   = 2,
  parameter int   SETTLE_SAMPLES = 10,
  parameter logic INIT_MODE      = 1'b0
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               mode_req,
  input  logic               mode_req_valid,
  input  logic [DATA_WL-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [DATA_WL-1:0] f_tdata,
  output logic               f_tvalid,
  output logic               f_ctrl,
  output logic               f_srst,
  input  logic [DATA_WL-1:0] f_m_tdata,
  input  logic               f_m_tvalid,
  output logic [DATA_WL-1:0] m_tdata,
  output logic               m_tvalid,
  output logic               mode,
  output logic               busy,
  output logic [15:0]        switch_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST  = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [FW-1:0] FLUSH_LAST  = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH, ST_SETTLE} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_drain_cnt, w_drain_cnt_nxt;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic [SW-1:0] r_settle_cnt, w_settle_cnt_nxt;
  logic          r_target, w_target_nxt;
  logic          r_switching, w_switching_nxt;
  logic          r_pend_v, w_pend_v_nxt;
  logic          r_pend_m, w_pend_m_nxt;
  logic          r_f_ctrl, w_ctrl_nxt;
  logic          r_s_tready, r_f_srst, r_blank, r_busy;
  logic [15:0]   r_switch_cnt;
  logic          w_cnt_inc, w_go_run, w_start, w_start_mode;

  always_comb begin
    w_state_nxt      = r_state;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_flush_cnt_nxt  = r_flush_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_target_nxt     = r_target;
    w_switching_nxt  = r_switching;
    w_pend_v_nxt     = r_pend_v;
    w_pend_m_nxt     = r_pend_m;
    w_ctrl_nxt       = r_f_ctrl;
    w_cnt_inc        = 1'b0;
    w_go_run         = 1'b0;
    w_start          = 1'b0;
    w_start_mode     = r_target;

    if (mode_req_valid && (r_state != ST_RUN)) begin
      w_pend_v_nxt = 1'b1;
      w_pend_m_nxt = mode_req;
    end

    case (r_state)
      ST_RUN: begin
        if (mode_req_valid && (mode_req != r_f_ctrl)) begin
          w_start      = 1'b1;
          w_start_mode = mode_req;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = '0;
          w_ctrl_nxt      = r_target;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_cnt_inc       = r_switching;
          w_switching_nxt = 1'b0;
          if (SETTLE_SAMPLES == 0) begin
            w_go_run = 1'b1;
          end else begin
            w_state_nxt      = ST_SETTLE;
            w_settle_cnt_nxt = '0;
          end
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + 1'b1;
        end
      end
      default: begin
        if (f_m_tvalid) begin
          if (r_settle_cnt == SETTLE_LAST) w_go_run = 1'b1;
          else                             w_settle_cnt_nxt = r_settle_cnt + 1'b1;
        end
      end
    endcase

    // A pending request (including one strobed this very cycle) is resolved
    // at the RUN boundary; a differing one goes straight to DRAIN.
    if (w_go_run) begin
      w_state_nxt  = ST_RUN;
      w_pend_v_nxt = 1'b0;
      if (w_pend_v_nxt == 1'b0 && r_pend_v == 1'b0 && !mode_req_valid) begin
        w_start = 1'b0;
      end else if ((mode_req_valid ? mode_req : r_pend_m) != r_f_ctrl) begin
        w_start      = 1'b1;
        w_start_mode = mode_req_valid ? mode_req : r_pend_m;
      end
    end

    if (w_start) begin
      w_target_nxt    = w_start_mode;
      w_switching_nxt = 1'b1;
      if (DRAIN_CYCLES > 0) begin
        w_state_nxt     = ST_DRAIN;
        w_drain_cnt_nxt = '0;
      end else begin
        w_state_nxt     = ST_FLUSH;
        w_flush_cnt_nxt = '0;
        w_ctrl_nxt      = w_start_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= ST_FLUSH;
      r_drain_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
      r_target     <= INIT_MODE;
      r_switching  <= 1'b0;
      r_pend_v     <= 1'b0;
      r_pend_m     <= 1'b0;
      r_f_ctrl     <= INIT_MODE;
      r_s_tready   <= 1'b0;
      r_f_srst     <= 1'b1;
      r_blank      <= 1'b1;
      r_busy       <= 1'b1;
      r_switch_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_target     <= w_target_nxt;
      r_switching  <= w_switching_nxt;
      r_pend_v     <= w_pend_v_nxt;
      r_pend_m     <= w_pend_m_nxt;
      r_f_ctrl     <= w_ctrl_nxt;
      r_s_tready   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_SETTLE);
      r_f_srst     <= (w_state_nxt == ST_FLUSH);
      r_blank      <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_SETTLE);
      r_busy       <= (w_state_nxt != ST_RUN);
      if (w_cnt_inc && (r_switch_cnt != '1)) r_switch_cnt <= r_switch_cnt + 16'd1;
    end
  end

  assign s_tready   = r_s_tready;
  assign f_tdata    = s_tdata;
  assign f_tvalid   = s_tvalid & r_s_tready;
  assign f_ctrl     = r_f_ctrl;
  assign f_srst     = r_f_srst;
  assign m_tdata    = f_m_tdata;
  assign m_tvalid   = f_m_tvalid & ~r_blank;
  assign mode       = r_f_ctrl;
  assign busy       = r_busy;
  assign switch_cnt = r_switch_cnt;

endmodule

// File: tb/tb_adaptive_filter_mode_ctrl.sv
// Bench for adaptive_filter_mode_ctrl: fixed vector table, directed corner sequences,
// and random traffic against a countdown-based reference model.
module tb_adaptive_filter_mode_ctrl;

  localparam int DATA_WL = 14;
  localparam int DRAIN_N = 1;
  localparam int FLUSH_N = 2;
  localparam int SETTLE_N = 10;

  logic               clk = 1'b0;
  logic               arst_n = 1'b0;
  logic               mode_req = 1'b0, mode_req_valid = 1'b0;
  logic [DATA_WL-1:0] s_tdata = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tready;
  logic [DATA_WL-1:0] f_tdata;
  logic               f_tvalid, f_ctrl, f_srst;
  logic [DATA_WL-1:0] f_m_tdata = '0;
  logic               f_m_tvalid = 1'b0;
  logic [DATA_WL-1:0] m_tdata;
  logic               m_tvalid, mode, busy;
  logic [15:0]        switch_cnt;

  adaptive_filter_mode_ctrl #(
    .DATA_WL(DATA_WL), .DRAIN_CYCLES(DRAIN_N), .FLUSH_CYCLES(FLUSH_N),
    .SETTLE_SAMPLES(SETTLE_N), .INIT_MODE(1'b0)
  ) dut (
    .clk(clk), .arst_n(arst_n), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .f_tdata(f_tdata), .f_tvalid(f_tvalid), .f_ctrl(f_ctrl), .f_srst(f_srst),
    .f_m_tdata(f_m_tdata), .f_m_tvalid(f_m_tvalid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .mode(mode), .busy(busy),
    .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: each phase is a countdown of what remains of it; all zero = running.
  int md_mode, md_target, md_pend, md_drain, md_flush, md_settle, md_cnt;
  bit md_sw;

  function automatic bit md_running();
    return (md_drain == 0) && (md_flush == 0) && (md_settle == 0);
  endfunction

  task automatic md_reset();
    md_mode = 0; md_target = 0; md_pend = -1; md_sw = 0; md_cnt = 0;
    md_drain = 0; md_flush = FLUSH_N; md_settle = 0;
  endtask

  task automatic md_start(input int m);
    md_target = m; md_sw = 1; md_drain = DRAIN_N;
  endtask

  task automatic md_update(input logic rv, input logic req, input logic fmv);
    int p;
    if (md_running()) begin
      if (rv && int'(req) != md_mode) md_start(int'(req));
    end else begin
      if (rv) md_pend = int'(req);
      if (md_drain > 0) begin
        md_drain--;
        if (md_drain == 0) begin md_flush = FLUSH_N; md_mode = md_target; end
      end else if (md_flush > 0) begin
        md_flush--;
        if (md_flush == 0) begin
          if (md_sw && md_cnt < 65535) md_cnt++;
          md_sw = 0;
          md_settle = SETTLE_N;
        end
      end else if (fmv) begin
        md_settle--;
        if (md_settle == 0) begin
          p = md_pend; md_pend = -1;
          if (p >= 0 && p != md_mode) md_start(p);
        end
      end
    end
  endtask

  task automatic check_model();
    logic run, rdy, blank;
    run = md_running();
    rdy = run || (md_settle > 0);
    blank = (md_flush > 0) || (md_settle > 0);
    chk("ctl{rdy,ftv,ctrl,srst,mtv,mode,busy}",
        64'({s_tready, f_tvalid, f_ctrl, f_srst, m_tvalid, mode, busy}),
        64'({rdy, s_tvalid & rdy, md_mode[0], md_flush > 0, f_m_tvalid & ~blank, md_mode[0], ~run}));
    chk("switch_cnt", 64'(switch_cnt), 64'(md_cnt));
    chk("passthru", 64'({f_tdata, m_tdata}), 64'({s_tdata, f_m_tdata}));
  endtask

  logic last_rdy, last_srst, last_ctrl, last_busy, last_mtv, last_fmv, prev_ftv = 1'b0;
  logic [15:0] last_cnt;

  task automatic cyc(input logic rst, input logic rv, input logic req, input logic sv, input logic fmv);
    @(negedge clk);
    arst_n = rst; mode_req_valid = rv; mode_req = req; s_tvalid = sv;
    s_tdata = DATA_WL'($urandom); f_m_tvalid = fmv; f_m_tdata = DATA_WL'($urandom);
    #1;
    if (!arst_n) md_reset();
    check_model();
    last_rdy = s_tready; last_srst = f_srst; last_ctrl = f_ctrl; last_busy = busy;
    last_mtv = m_tvalid; last_fmv = f_m_tvalid; last_cnt = switch_cnt;
    prev_ftv = f_tvalid;
    if (arst_n) md_update(rv, req, fmv);
    @(posedge clk);
  endtask

  // Streams samples through a 1-cycle filter stand-in until the block is back in RUN.
  task automatic settle_loop(output int n_srst, output int n_blank);
    int n;
    n_srst = 0; n_blank = 0;
    for (n = 0; n < 300; n++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, prev_ftv);
      if (last_srst) n_srst++;
      if (last_fmv && !last_mtv) n_blank++;
      if (!last_busy) break;
    end
    if (n >= 300) chk("settle_timeout", 64'(1), 64'(0));
  endtask

  typedef struct {
    logic [8:0]  v;   // {rv, req, sv, fmv, exp rdy, exp srst, exp ctrl, exp busy, exp mtv}
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [8:0] v, input logic [15:0] c);
    vec_t e;
    e.v = v; e.cnt = c;
    tbl.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nb, nbusy;
    vec_t e;

    add(9'b1011_10001, 16'd0);   // same-mode strobe: ignored
    add(9'b0011_10001, 16'd0);
    add(9'b0011_10001, 16'd0);
    add(9'b1111_10001, 16'd0);   // strobe to mode 1 at t, sample accepted
    add(9'b0011_00011, 16'd0);   // t+1 drain, old output visible
    add(9'b0010_01110, 16'd0);   // t+2 flush, ctrl=1
    add(9'b0010_01110, 16'd0);   // t+3
    add(9'b0010_10110, 16'd1);   // t+4 settle
    for (int i = 0; i < SETTLE_N; i++) add(9'b0011_10110, 16'd1);
    add(9'b0011_10101, 16'd1);   // back in RUN

    // Reset state and reset flush
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_mtv_blank", 64'(last_mtv), 64'(0));
    settle_loop(ns, nb);
    chk("rst_srst_cycles", 64'(ns), 64'(2));
    chk("rst_blanked", 64'(nb), 64'(10));
    chk("rst_run_mode", 64'({last_rdy, last_ctrl}), 64'(2'b10));

    // Reset dropped mid-flush of a switch to mode 1
    cyc(1'b1, 1'b1, 1'b1, 1'b1, prev_ftv);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, prev_ftv);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, prev_ftv);
    chk("midflush_state", 64'({last_srst, last_ctrl}), 64'(2'b11));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, prev_ftv);
    chk("midrst_mode_cnt", 64'({last_ctrl, last_cnt}), 64'(0));
    settle_loop(ns, nb);
    chk("midrst_srst_cycles", 64'(ns), 64'(2));
    chk("midrst_blanked", 64'(nb), 64'(10));

    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      cyc(1'b1, e.v[8], e.v[7], e.v[6], e.v[5]);
      chk($sformatf("tbl[%0d]", i), 64'({last_rdy, last_srst, last_ctrl, last_busy, last_mtv}), 64'(e.v[4:0]));
      chk($sformatf("tbl_cnt[%0d]", i), 64'(last_cnt), 64'(e.cnt));
    end

    // Pending request during FLUSH triggers a back-to-back second switch
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle_loop(ns, nb);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, prev_ftv);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, prev_ftv);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, prev_ftv);
    settle_loop(ns, nb);
    chk("pend_srst_cycles", 64'(ns), 64'(3));
    chk("pend_blanked", 64'(nb), 64'(20));
    chk("pend_cnt_mode", 64'({last_cnt, last_ctrl}), 64'({16'd2, 1'b0}));

    // Stalled input holds SETTLE
    cyc(1'b1, 1'b1, 1'b1, 1'b1, prev_ftv);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, prev_ftv);
    nbusy = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (last_busy && last_rdy && !last_srst) nbusy++;
    end
    chk("stall_busy", 64'(nbusy), 64'(50));
    nbusy = 0;
    for (int i = 0; i < SETTLE_N; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (last_busy && !last_mtv) nbusy++;
    end
    chk("stall_outputs_blanked", 64'(nbusy), 64'(10));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_done", 64'({last_busy, last_mtv, last_ctrl, last_cnt}), 64'({3'b011, 16'd3}));

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), 1'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
